// File: rtl/delay_line_pkg.sv
// Shared helpers for the run-time programmable delay line.
package delay_line_pkg;

  function automatic int sel_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// One pipeline slot: a payload word plus its valid tag.
`define DELAY_LINE_STAGE_T(W) typedef struct packed { logic valid; logic [(W)-1:0] data; } stage_t;

// File: rtl/delay_stage.sv
// Single delay-line slot: the word advances on enable, and its valid flag can be cleared on its own.
module delay_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  valid_d,
  input  logic [DATA_WIDTH-1:0] data_d,
  output logic                  valid_q,
  output logic [DATA_WIDTH-1:0] data_q
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: a clear drops only the valid flag; the data still shifts when enabled.
      if (en_i) data_q <= data_d;
      if (clr_i)     valid_q <= 1'b0;
      else if (en_i) valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/delay_line_var.sv
// Stallable delay line with a run-time delay select of 0..MAX_DELAY cycles and a valid tag per word.
module delay_line_var
  import delay_line_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_DELAY  = 4,
  localparam int SEL_WIDTH  = sel_width(MAX_DELAY)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [SEL_WIDTH-1:0]  delay_sel_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SEL_WIDTH-1:0]  delay_o,
  output logic                  sel_chg_o
);

  `DELAY_LINE_STAGE_T(DATA_WIDTH)

  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_DELAY);

  logic [SEL_WIDTH-1:0]  sel_clamped;
  logic [SEL_WIDTH-1:0]  delay_ff;
  logic                  sel_change;
  logic                  clear;
  logic                  sel_chg_ff;
  logic                  v_chain [MAX_DELAY+1];
  logic [DATA_WIDTH-1:0] d_chain [MAX_DELAY+1];
  stage_t                tap;

  assign sel_clamped = (delay_sel_i > MAX_SEL) ? MAX_SEL : delay_sel_i;
  assign sel_change  = (sel_clamped != delay_ff);
  // A delay change invalidates every in-flight word so nothing leaves with the wrong alignment.
  assign clear       = flush_i | sel_change;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      delay_ff   <= MAX_SEL;
      sel_chg_ff <= 1'b0;
    end else begin
      delay_ff   <= sel_clamped;
      sel_chg_ff <= sel_change;
    end
  end

  assign v_chain[0] = valid_i;
  assign d_chain[0] = data_i;

  for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
    delay_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .en_i   (en_i),
      .clr_i  (clear),
      .valid_d(v_chain[k]),
      .data_d (d_chain[k]),
      .valid_q(v_chain[k+1]),
      .data_q (d_chain[k+1])
    );
  end

  always_comb begin
    // NOTE: default first so the tap mux stays purely combinational.
    tap = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (delay_ff == SEL_WIDTH'(k)) tap = '{valid: v_chain[k], data: d_chain[k]};
    end
    if (delay_ff == '0) tap = '{valid: valid_i & en_i, data: data_i};
  end

  assign valid_o   = tap.valid;
  assign data_o    = tap.data;
  assign delay_o   = delay_ff;
  assign sel_chg_o = sel_chg_ff;

endmodule

// File: tb/tb_delay_line_var.sv
// Randomized and directed bench for delay_line_var against a queue-based history model.
module tb_delay_line_var;
  import delay_line_pkg::*;

  localparam int DW = 8;
  localparam int MD = 4;
  localparam int SW = sel_width(MD);
  localparam int VW = DW + SW + 2;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          en_i;
  logic          flush_i;
  logic [SW-1:0] delay_sel_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [SW-1:0] delay_o;
  logic          sel_chg_o;

  int passed = 0;
  int total  = 0;

  typedef struct packed { logic v; logic [DW-1:0] d; } word_t;
  word_t hist[$];   // words accepted on enabled cycles, newest last
  int    m_delay;
  bit    m_chg;

  always #5 clk_i = ~clk_i;

  delay_line_var #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .en_i       (en_i),
    .flush_i    (flush_i),
    .delay_sel_i(delay_sel_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .delay_o    (delay_o),
    .sel_chg_o  (sel_chg_o)
  );

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < MD; i++) hist.push_back('0);
    m_delay = MD;
    m_chg   = 1'b0;
  endfunction

  function automatic void model_update();
    int c;
    bit change;
    bit clr;
    c      = (int'(delay_sel_i) > MD) ? MD : int'(delay_sel_i);
    change = (c != m_delay);
    clr    = flush_i | change;
    if (en_i) begin
      hist.push_back('{v: valid_i & ~clr, d: data_i});
      void'(hist.pop_front());
    end
    if (clr) foreach (hist[i]) hist[i].v = 1'b0;
    m_delay = c;
    m_chg   = change;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    word_t w;
    if (m_delay == 0) w = '{v: valid_i & en_i, d: data_i};
    else              w = hist[hist.size() - m_delay];
    return {w.v, w.d, SW'(m_delay), m_chg};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {valid_o, data_o, delay_o, sel_chg_o};
  endfunction

  task automatic drive(input bit en, input bit fl, input int sel, input bit v, input logic [DW-1:0] d);
    en_i        = en;
    flush_i     = fl;
    delay_sel_i = SW'(sel);
    valid_i     = v;
    data_i      = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    drive(1'b1, 1'b0, MD, 1'b0, 8'h00);
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if (obs_vec() !== {1'b0, 8'h00, SW'(MD), 1'b0})
      $display("FAIL reset_state: got %h want %h", obs_vec(), {1'b0, 8'h00, SW'(MD), 1'b0});
    else passed++;
    arst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_delay3();
    int pulses = 0;
    drive(1'b1, 1'b0, 3, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 3, i < 8, (i < 8) ? DW'(i + 1) : 8'h00);
      if (sel_chg_o) pulses++;
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL delay3 cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i <= 3) begin
        total++;
        if ({valid_o, (i == 3) ? data_o : 8'h00} !== {i == 3, (i == 3) ? 8'h01 : 8'h00})
          $display("FAIL delay3_first cyc %0d: got v=%b d=%h want v=%b d=01", i, valid_o, data_o, i == 3);
        else passed++;
      end
      tick();
    end
    total++;
    if (pulses !== 1) $display("FAIL delay3_chg_pulses: got %0d want 1", pulses);
    else passed++;
  endtask

  task automatic test_passthrough();
    drive(1'b1, 1'b0, 0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 0, 1'b1, 8'hA5);
    total++;
    if ({valid_o, data_o, delay_o} !== {1'b1, 8'hA5, SW'(0)})
      $display("FAIL passthrough: got %h want %h", {valid_o, data_o, delay_o}, {1'b1, 8'hA5, SW'(0)});
    else passed++;
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL passthrough_model: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    logic [DW:0] snap;
    for (int i = 0; i < 16; i++) begin
      bit stall;
      stall = (i >= 6 && i < 9);
      drive(!stall, 1'b0, 2, 1'b1, DW'(8'h20 + i));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL stall cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i == 6) snap = {valid_o, data_o};
      if (i == 7 || i == 8) begin
        total++;
        if ({valid_o, data_o} !== snap) $display("FAIL stall_frozen cyc %0d: got %h want %h", i, {valid_o, data_o}, snap);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_clamp_switch();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 7, i > 0, DW'(8'h30 + i));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL clamp cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    total++;
    if (delay_o !== SW'(MD)) $display("FAIL clamp_delay_o: got %0d want %0d", delay_o, MD);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1, 1'b1, DW'(8'h40 + i));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL switch1 cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i == 1) begin
        total++;
        if ({valid_o, sel_chg_o, delay_o} !== {1'b0, 1'b1, SW'(1)})
          $display("FAIL switch1_edge: got %b want %b", {valid_o, sel_chg_o, delay_o}, {1'b0, 1'b1, SW'(1)});
        else passed++;
      end
      if (i == 2) begin
        total++;
        if ({valid_o, data_o, sel_chg_o} !== {1'b1, 8'h41, 1'b0})
          $display("FAIL switch1_next: got %h want %h", {valid_o, data_o, sel_chg_o}, {1'b1, 8'h41, 1'b0});
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4, 1'b1, DW'(8'h60 + i));
      tick();
    end
    for (int k = 0; k <= 6; k++) begin
      drive(1'b1, k == 0, 4, 1'b1, DW'(8'h70 + k));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL flush cyc %0d: got %h want %h", k, obs_vec(), exp_vec());
      else passed++;
      if (k >= 1 && k <= 4) begin
        total++;
        if (valid_o !== 1'b0) $display("FAIL flush_quiet cyc %0d: got %b want 0", k, valid_o);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if ({valid_o, data_o} !== {1'b1, 8'h71}) $display("FAIL flush_resume: got %h want %h", {valid_o, data_o}, {1'b1, 8'h71});
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4, 1'b1, DW'(8'h80 + i));
      tick();
    end
    @(posedge clk_i);
    model_update();
    #2;
    arst_i = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    #1;
    total++;
    if ({valid_o, data_o, delay_o} !== {1'b0, 8'h00, SW'(MD)})
      $display("FAIL async_reset: got %h want %h", {valid_o, data_o, delay_o}, {1'b0, 8'h00, SW'(MD)});
    else passed++;
    @(negedge clk_i);
    #2;
    arst_i = 1'b0;
    @(negedge clk_i);
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 4, i >= 2, DW'(8'h90 + i));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL post_reset cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (i < 6) begin
        total++;
        if (valid_o !== 1'b0) $display("FAIL post_reset_spurious cyc %0d: got %b want 0", i, valid_o);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int sel = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) sel = $urandom_range(7);
      drive($urandom_range(7) != 0, $urandom_range(15) == 0, sel, $urandom_range(1) == 1, DW'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_delay3();
    test_passthrough();
    test_stall();
    test_clamp_switch();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
